// File: rtl/inst_fetch.sv
// Instruction fetch responder: owns the program counter, reads instruction memory
// on request from control, and applies branch/jump redirection on execute.
module inst_fetch #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iFETCH,
  input  logic              iEXEC,
  input  logic              iIS_TAKEN,
  input  logic              iIS_JUMP,
  input  logic              iIS_ABS,
  input  logic [ADDR_W-1:0] iIMM,
  input  logic [ADDR_W-1:0] iRS2_VAL,
  input  logic              iHALT,
  output logic [11:0]       oINST,
  output logic              oINST_VALID,
  output logic [ADDR_W-1:0] oINST_PC,
  output logic [ADDR_W-1:0] oLINK,
  output logic [ADDR_W-1:0] oPC,
  output logic              oMEM_RD,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  input  logic [11:0]       iMEM_DATA,
  input  logic              iMEM_READY,
  output logic              oBUSY
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state;
  logic   pending;

  // Redirect priority: register jump (absolute, then relative), then taken branch.
  // Without a redirect the PC already points at the sequential successor.
  function automatic logic [ADDR_W-1:0] redirectPc(
    input logic              isJump,
    input logic              isAbs,
    input logic              isTaken,
    input logic [ADDR_W-1:0] instPc,
    input logic [ADDR_W-1:0] imm,
    input logic [ADDR_W-1:0] rs2Val,
    input logic [ADDR_W-1:0] curPc
  );
    logic [ADDR_W-1:0] nextPc;
    nextPc = curPc;
    if (isJump && isAbs)
      nextPc = rs2Val;
    else if (isJump)
      nextPc = instPc + rs2Val;
    else if (isTaken)
      nextPc = instPc + imm;
    return nextPc;
  endfunction

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state       <= IDLE;
      pending     <= 1'b0;
      oPC         <= RESET_PC;
      oINST       <= '0;
      oINST_VALID <= 1'b0;
      oINST_PC    <= '0;
      oLINK       <= ADDR_W'(1);
      oMEM_RD     <= 1'b0;
      oMEM_ADDR   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((iFETCH || pending) && !iHALT) begin
            oMEM_ADDR <= oPC;
            oMEM_RD   <= 1'b1;
            pending   <= 1'b0;
            state     <= REQ;
          end else if (iFETCH) begin
            // A fetch arriving while halted waits for the halt to lift.
            pending <= 1'b1;
          end
        end
        REQ: begin
          if (iMEM_READY) begin
            oINST       <= iMEM_DATA;
            oINST_PC    <= oMEM_ADDR;
            oLINK       <= oMEM_ADDR + ADDR_W'(1);
            oPC         <= oMEM_ADDR + ADDR_W'(1);
            oINST_VALID <= 1'b1;
            oMEM_RD     <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (iFETCH)
            pending <= 1'b1;
          if (iEXEC) begin
            oPC         <= redirectPc(iIS_JUMP, iIS_ABS, iIS_TAKEN, oINST_PC,
                                      iIMM, iRS2_VAL, oPC);
            oINST_VALID <= 1'b0;
            oINST       <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a wait-state memory model answers reads and
// each scenario task checks the fetch/redirect behaviour against its own expectations.
module tb_inst_fetch;

  logic        iCLK;
  logic        iRSTn;
  logic        iFETCH, iEXEC, iIS_TAKEN, iIS_JUMP, iIS_ABS, iHALT;
  logic [11:0] iIMM, iRS2_VAL;
  logic [11:0] oINST, oINST_PC, oLINK, oPC, oMEM_ADDR, iMEM_DATA;
  logic        oINST_VALID, oMEM_RD, iMEM_READY, oBUSY;

  typedef struct {
    logic [11:0] addr;
    logic [11:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mem [4096];
  int          memWait;
  int          waitLeft;
  logic        lateReady;
  int          checks;
  int          failures;

  inst_fetch #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iFETCH(iFETCH), .iEXEC(iEXEC),
    .iIS_TAKEN(iIS_TAKEN), .iIS_JUMP(iIS_JUMP), .iIS_ABS(iIS_ABS),
    .iIMM(iIMM), .iRS2_VAL(iRS2_VAL), .iHALT(iHALT),
    .oINST(oINST), .oINST_VALID(oINST_VALID), .oINST_PC(oINST_PC),
    .oLINK(oLINK), .oPC(oPC), .oMEM_RD(oMEM_RD), .oMEM_ADDR(oMEM_ADDR),
    .iMEM_DATA(iMEM_DATA), .iMEM_READY(iMEM_READY), .oBUSY(oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Memory model: READY rises memWait cycles after the request appears.
  always @(posedge iCLK) begin
    if (!oMEM_RD)
      waitLeft <= memWait;
    else if (waitLeft > 0)
      waitLeft <= waitLeft - 1;
  end
  assign iMEM_READY = (oMEM_RD && waitLeft == 0) || lateReady;
  assign iMEM_DATA  = mem[oMEM_ADDR];

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (oINST_VALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doFetch(output bit ok);
    @(negedge iCLK);
    iFETCH = 1'b1;
    @(negedge iCLK);
    iFETCH = 1'b0;
    if (oINST_VALID === 1'b1) ok = 1'b1;
    else waitValid(ok);
  endtask

  task automatic doExec(input logic taken, input logic jump, input logic abs,
                        input logic [11:0] imm, input logic [11:0] rs2);
    @(negedge iCLK);
    iEXEC = 1'b1; iIS_TAKEN = taken; iIS_JUMP = jump; iIS_ABS = abs;
    iIMM = imm; iRS2_VAL = rs2;
    @(negedge iCLK);
    iEXEC = 1'b0; iIS_TAKEN = 1'b0; iIS_JUMP = 1'b0; iIS_ABS = 1'b0;
    iIMM = '0; iRS2_VAL = '0;
  endtask

  task automatic test_reset;
    iRSTn = 1'b0;
    repeat (2) @(negedge iCLK);
    checks++; if (oPC !== 12'h000) begin failures++; $display("FAIL rst_pc actual=%h required=%h", oPC, 12'h000); end
    checks++; if (oINST !== 12'h000 || oINST_VALID !== 1'b0) begin failures++; $display("FAIL rst_inst actual=%h/%b required=000/0", oINST, oINST_VALID); end
    checks++; if (oINST_PC !== 12'h000 || oLINK !== 12'h001) begin failures++; $display("FAIL rst_pc_link actual=%h/%h required=000/001", oINST_PC, oLINK); end
    checks++; if (oMEM_RD !== 1'b0 || oMEM_ADDR !== 12'h000 || oBUSY !== 1'b0) begin failures++; $display("FAIL rst_mem actual=%b/%h/%b required=0/000/0", oMEM_RD, oMEM_ADDR, oBUSY); end
    iRSTn = 1'b1;
  endtask

  task automatic test_zero_wait;
    exp_t e;
    iFETCH = 1'b1;
    sb.push_back('{12'h000, mem[0]});
    @(negedge iCLK);
    iFETCH = 1'b0;
    checks++; if (oMEM_RD !== 1'b1 || oMEM_ADDR !== 12'h000) begin failures++; $display("FAIL zw_req actual=%b/%h required=1/000", oMEM_RD, oMEM_ADDR); end
    @(negedge iCLK);
    checks++; if (oINST_VALID !== 1'b1) begin failures++; $display("FAIL zw_valid actual=%b required=1", oINST_VALID); end
    e = sb.pop_front();
    checks++; if (oINST !== e.inst || oINST !== 12'o1234) begin failures++; $display("FAIL zw_inst actual=%o required=%o", oINST, e.inst); end
    checks++; if (oINST_PC !== e.addr || oLINK !== 12'h001 || oPC !== 12'h001) begin failures++; $display("FAIL zw_pc actual=%h/%h/%h required=000/001/001", oINST_PC, oLINK, oPC); end
  endtask

  task automatic test_branch;
    bit ok;
    exp_t e;
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'h010);
    checks++; if (oPC !== 12'h010) begin failures++; $display("FAIL br_setup actual=%h required=%h", oPC, 12'h010); end
    sb.push_back('{12'h010, mem[12'h010]});
    doFetch(ok);
    e = sb.pop_front();
    checks++; if (!ok || oINST !== e.inst || oINST_PC !== e.addr) begin failures++; $display("FAIL br_fetch actual=%h@%h required=%h@%h", oINST, oINST_PC, e.inst, e.addr); end
    doExec(1'b1, 1'b0, 1'b0, 12'hFFC, 12'h000);
    checks++; if (oPC !== 12'h00C) begin failures++; $display("FAIL br_pc actual=%h required=%h", oPC, 12'h00C); end
    checks++; if (oINST_VALID !== 1'b0 || oINST !== 12'h000 || oBUSY !== 1'b0) begin failures++; $display("FAIL br_idle actual=%b/%h/%b required=0/000/0", oINST_VALID, oINST, oBUSY); end
  endtask

  task automatic test_jump;
    bit ok;
    doFetch(ok);
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'h020);
    doFetch(ok);
    checks++; if (!ok || oINST_PC !== 12'h020 || oLINK !== 12'h021) begin failures++; $display("FAIL jabs_link actual=%h/%h required=020/021", oINST_PC, oLINK); end
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'h300);
    checks++; if (oPC !== 12'h300) begin failures++; $display("FAIL jabs_pc actual=%h required=%h", oPC, 12'h300); end
    doFetch(ok);
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'h020);
    doFetch(ok);
    // Taken branch also asserted: the register jump must win.
    doExec(1'b1, 1'b1, 1'b0, 12'h100, 12'h005);
    checks++; if (oPC !== 12'h025) begin failures++; $display("FAIL jrel_pc actual=%h required=%h", oPC, 12'h025); end
  endtask

  task automatic test_wrap;
    bit ok;
    exp_t e;
    doFetch(ok);
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'hFFF);
    memWait = 3;
    @(negedge iCLK);
    iFETCH = 1'b1;
    sb.push_back('{12'hFFF, mem[12'hFFF]});
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      iFETCH = 1'b0;
      checks++; if (oMEM_RD !== 1'b1 || oMEM_ADDR !== 12'hFFF || oINST_VALID !== 1'b0) begin failures++; $display("FAIL wrap_hold%0d actual=%b/%h/%b required=1/fff/0", i, oMEM_RD, oMEM_ADDR, oINST_VALID); end
    end
    waitValid(ok);
    e = sb.pop_front();
    checks++; if (!ok || oINST !== e.inst || oINST_PC !== e.addr) begin failures++; $display("FAIL wrap_inst actual=%h@%h required=%h@%h", oINST, oINST_PC, e.inst, e.addr); end
    checks++; if (oPC !== 12'h000 || oLINK !== 12'h000) begin failures++; $display("FAIL wrap_pc actual=%h/%h required=000/000", oPC, oLINK); end
    memWait = 0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    exp_t e;
    doExec(1'b0, 1'b1, 1'b1, 12'h000, 12'h040);
    doFetch(ok);
    @(negedge iCLK);
    iFETCH = 1'b1; iEXEC = 1'b1; iIS_TAKEN = 1'b1; iIMM = 12'h008;
    sb.push_back('{12'h048, mem[12'h048]});
    @(negedge iCLK);
    iFETCH = 1'b0; iEXEC = 1'b0; iIS_TAKEN = 1'b0; iIMM = '0;
    checks++; if (oBUSY !== 1'b0 || oPC !== 12'h048 || oMEM_RD !== 1'b0) begin failures++; $display("FAIL b2b_idle actual=%b/%h/%b required=0/048/0", oBUSY, oPC, oMEM_RD); end
    @(negedge iCLK);
    checks++; if (oMEM_RD !== 1'b1 || oMEM_ADDR !== 12'h048) begin failures++; $display("FAIL b2b_req actual=%b/%h required=1/048", oMEM_RD, oMEM_ADDR); end
    waitValid(ok);
    e = sb.pop_front();
    checks++; if (!ok || oINST !== e.inst || oINST_PC !== e.addr) begin failures++; $display("FAIL b2b_inst actual=%h@%h required=%h@%h", oINST, oINST_PC, e.inst, e.addr); end
  endtask

  task automatic test_halt;
    bit ok;
    exp_t e;
    doExec(1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    checks++; if (oPC !== 12'h049) begin failures++; $display("FAIL halt_seq_pc actual=%h required=%h", oPC, 12'h049); end
    @(negedge iCLK);
    iHALT = 1'b1; iFETCH = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      checks++; if (oMEM_RD !== 1'b0 || oBUSY !== 1'b0) begin failures++; $display("FAIL halt_block%0d actual=%b/%b required=0/0", i, oMEM_RD, oBUSY); end
    end
    iHALT = 1'b0;
    sb.push_back('{12'h049, mem[12'h049]});
    @(negedge iCLK);
    iFETCH = 1'b0;
    checks++; if (oMEM_RD !== 1'b1 || oMEM_ADDR !== 12'h049) begin failures++; $display("FAIL halt_release actual=%b/%h required=1/049", oMEM_RD, oMEM_ADDR); end
    waitValid(ok);
    e = sb.pop_front();
    checks++; if (!ok || oINST !== e.inst || oINST_PC !== e.addr) begin failures++; $display("FAIL halt_inst actual=%h@%h required=%h@%h", oINST, oINST_PC, e.inst, e.addr); end
  endtask

  task automatic test_reset_mid_read;
    doExec(1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    memWait = 5;
    @(negedge iCLK);
    iFETCH = 1'b1;
    @(negedge iCLK);
    iFETCH = 1'b0;
    checks++; if (oMEM_RD !== 1'b1 || oMEM_ADDR !== 12'h04A) begin failures++; $display("FAIL rmr_req actual=%b/%h required=1/04a", oMEM_RD, oMEM_ADDR); end
    iRSTn = 1'b0;
    @(negedge iCLK);
    iRSTn = 1'b1; lateReady = 1'b1;
    @(negedge iCLK);
    lateReady = 1'b0;
    checks++; if (oMEM_RD !== 1'b0 || oINST_VALID !== 1'b0 || oINST !== 12'h000) begin failures++; $display("FAIL rmr_drop actual=%b/%b/%h required=0/0/000", oMEM_RD, oINST_VALID, oINST); end
    checks++; if (oPC !== 12'h000 || oBUSY !== 1'b0) begin failures++; $display("FAIL rmr_pc actual=%h/%b required=000/0", oPC, oBUSY); end
    memWait = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    memWait = 0; lateReady = 1'b0;
    iRSTn = 1'b0; iFETCH = 1'b0; iEXEC = 1'b0; iIS_TAKEN = 1'b0;
    iIS_JUMP = 1'b0; iIS_ABS = 1'b0; iHALT = 1'b0; iIMM = '0; iRS2_VAL = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i * 7 + 12'h3A5);
    mem[0] = 12'o1234;

    test_reset;
    test_zero_wait;
    test_branch;
    test_jump;
    test_wrap;
    test_back_to_back;
    test_halt;
    test_reset_mid_read;

    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain actual=%0d required=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
